// File: rtl/ucca_reset_ctrl.sv
// ucca_reset_ctrl: violation-to-reset controller for UCCA.
//
// Merges the CR integrity violation and all UCC region violations into one
// MCU reset. The reset is held for RST_HOLD cycles after the last violation.
// The first violation's cause is recorded in a sticky status word that
// software reads back after reboot.
//
// Optional feature macro: UCCA_VIOL_LOG_EN
//   defined   -> COUNT field counts violation episodes (saturating at 63),
//                and a PC log register at CAUSE_ADDR+2 captures the PC of
//                the first violation.
//   undefined -> COUNT reads 0, CAUSE_ADDR+2 reads 0, no PC register exists.
//
// Cause word layout: [15] VALID, [14] OVF, [13:8] COUNT, [7:4] zero, [3:0] SRC.
// SRC is 0 for CR, and i+1 for UCC i. CR has priority, then the lowest UCC index.

module ucca_reset_ctrl #(
    parameter int          NUM_UCC    = 4,
    parameter logic [15:0] RST_HOLD   = 16'd8,
    parameter logic [15:0] CAUSE_ADDR = 16'h0130
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cr_viol,
    input  logic [NUM_UCC-1:0] ucc_viol,
    input  logic [15:0]        pc,
    input  logic               data_en,
    input  logic               data_wr,
    input  logic [15:0]        data_addr,
    input  logic [15:0]        data_din,
    output logic               mcu_reset,
    output logic [15:0]        cause_dout
);

    localparam logic [15:0] CLEAR_KEY = 16'hC1EA;
    localparam logic [15:0] PC_ADDR   = CAUSE_ADDR + 16'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t      state_q;
    logic [15:0] cnt_q;

    logic        any_viol;
    logic        episode_start;
    logic        clear_hit;
    logic [3:0]  viol_src;

    logic        valid_q, valid_d;
    logic        ovf_q,   ovf_d;
    logic [3:0]  src_q,   src_d;
    logic [5:0]  count_w;
    logic [15:0] pc_word;
    logic [15:0] cause_word;

    logic        rd_cause;
    logic        rd_pc;
    logic [15:0] dout_q, dout_d;

    assign any_viol = cr_viol | (|ucc_viol);

    // The MCU reset is combinational so the violating access never commits;
    // power-on reset masks it so the core is not double-reset.
    assign mcu_reset = ~reset & (any_viol | (state_q == ST_HOLD));

    // A new violation episode starts only when the controller leaves IDLE;
    // further violation cycles inside a hold count as the same event.
    assign episode_start = any_viol & (state_q == ST_IDLE);

    // Clear is only honoured while idle and violation-free; a same-cycle
    // violation wins over the clear.
    assign clear_hit = data_en & data_wr & (data_addr == CAUSE_ADDR) &
                       (data_din == CLEAR_KEY) & (state_q == ST_IDLE) & ~any_viol;

    // Priority encode the violation source: CR first, then lowest UCC index.
    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        viol_src = 4'd0;
        if (!cr_viol) begin
            for (int i = NUM_UCC - 1; i >= 0; i--) begin
                if (ucc_viol[i]) viol_src = 4'(i + 1);
            end
        end
    end

    // Reset hold FSM: reload the hold counter on every violation cycle and
    // return to IDLE once it has run down.
    // NOTE: sequential state is assigned with non-blocking (<=) so all
    // registers update together at the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_viol) begin
                        state_q <= ST_HOLD;
                        cnt_q   <= RST_HOLD - 16'd1;
                    end
                end
                ST_HOLD: begin
                    if (any_viol) begin
                        cnt_q <= RST_HOLD - 16'd1;
                    end else if (cnt_q == 16'd0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= 16'd0;
                end
            endcase
        end
    end

    // Next value of the sticky VALID/OVF/SRC fields.
    always_comb begin
        valid_d = valid_q;
        ovf_d   = ovf_q;
        src_d   = src_q;
        if (episode_start) begin
            if (!valid_q) begin
                valid_d = 1'b1;
                src_d   = viol_src;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (clear_hit) begin
            valid_d = 1'b0;
            ovf_d   = 1'b0;
            src_d   = 4'd0;
        end
    end

    // Sticky cause fields; they survive mcu_reset and only power-on reset or a
    // software clear zeroes them.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            src_q   <= 4'd0;
        end else begin
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            src_q   <= src_d;
        end
    end

`ifdef UCCA_VIOL_LOG_EN
    logic [5:0]  count_q, count_d;
    logic [15:0] pclog_q, pclog_d;

    // Episode counter (saturating) and PC capture at the first violation.
    always_comb begin
        count_d = count_q;
        pclog_d = pclog_q;
        if (episode_start) begin
            if (count_q != 6'd63) count_d = count_q + 6'd1;
            if (!valid_q)         pclog_d = pc;
        end else if (clear_hit) begin
            count_d = 6'd0;
            pclog_d = 16'd0;
        end
    end

    // Log registers share the cause word's reset and clear behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 6'd0;
            pclog_q <= 16'd0;
        end else begin
            count_q <= count_d;
            pclog_q <= pclog_d;
        end
    end

    assign count_w = count_q;
    assign pc_word = pclog_q;
`else
    // Without logging the PC input is not needed.
    logic unused_pc;
    assign unused_pc = ^pc;

    assign count_w = 6'd0;
    assign pc_word = 16'd0;
`endif

    assign cause_word = {valid_q, ovf_q, count_w, 4'd0, src_q};

    assign rd_cause = data_en & ~data_wr & (data_addr == CAUSE_ADDR);
    assign rd_pc    = data_en & ~data_wr & (data_addr == PC_ADDR);

    // Read mux: returns register contents as they stand in the request cycle.
    always_comb begin
        dout_d = 16'd0;
        if (rd_cause)   dout_d = cause_word;
        else if (rd_pc) dout_d = pc_word;
    end

    // Registered read data, valid the cycle after the request and 0 otherwise.
    always_ff @(posedge clk) begin
        if (reset) dout_q <= 16'd0;
        else       dout_q <= dout_d;
    end

    assign cause_dout = dout_q;

endmodule

// File: tb/tb_ucca_reset_ctrl.sv
// tb_ucca_reset_ctrl: directed and randomized bench for ucca_reset_ctrl.
// Expected values come from a cycle-level behavioural model that tracks the
// distance to the last violation and the sticky cause fields.

module tb_ucca_reset_ctrl;

    localparam int          NUM_UCC = 4;
    localparam int          H       = 8;
    localparam logic [15:0] CA      = 16'h0130;
    localparam logic [15:0] KEY     = 16'hC1EA;
    localparam int          FAR     = 100000;
`ifdef UCCA_VIOL_LOG_EN
    localparam bit          LOG     = 1'b1;
`else
    localparam bit          LOG     = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic               cr_viol;
    logic [NUM_UCC-1:0] ucc_viol;
    logic [15:0]        pc;
    logic               data_en;
    logic               data_wr;
    logic [15:0]        data_addr;
    logic [15:0]        data_din;
    logic               mcu_reset;
    logic [15:0]        cause_dout;

    always #5 clk = ~clk;

    ucca_reset_ctrl #(
        .NUM_UCC    (NUM_UCC),
        .RST_HOLD   (16'(H)),
        .CAUSE_ADDR (CA)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cr_viol    (cr_viol),
        .ucc_viol   (ucc_viol),
        .pc         (pc),
        .data_en    (data_en),
        .data_wr    (data_wr),
        .data_addr  (data_addr),
        .data_din   (data_din),
        .mcu_reset  (mcu_reset),
        .cause_dout (cause_dout)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state.
    bit          m_valid;
    bit          m_ovf;
    int          m_count;
    logic [3:0]  m_src;
    logic [15:0] m_pclog;
    logic [15:0] m_dout;
    int          m_since;   // cycles since last violation cycle (FAR = none)
    logic        obs_mcu;

    function automatic bit m_hold();
        return (m_since >= 1) && (m_since <= H);
    endfunction

    function automatic logic [15:0] m_word();
        logic [5:0] c;
        c = LOG ? 6'(m_count) : 6'd0;
        return {m_valid, m_ovf, c, 4'd0, m_src};
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_count = 0;
        m_src   = 4'd0;
        m_pclog = 16'd0;
        m_dout  = 16'd0;
        m_since = FAR;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the inputs currently applied: compare outputs,
    // advance the model, then step past the rising edge.
    task automatic tick();
        bit          viol;
        bit          exp_m;
        logic [15:0] nd;
        #2;
        viol  = cr_viol || (ucc_viol != '0);
        exp_m = !reset && (viol || m_hold());
        obs_mcu = mcu_reset;
        check("mcu_reset", 16'(mcu_reset), 16'(exp_m));
        check("cause_dout", cause_dout, m_dout);
        if (reset) begin
            model_reset();
        end else begin
            nd = 16'd0;
            if (data_en && !data_wr) begin
                if (data_addr == CA)              nd = m_word();
                else if (data_addr == CA + 16'd2) nd = LOG ? m_pclog : 16'd0;
            end
            if (viol && !m_hold()) begin
                if (!m_valid) begin
                    m_valid = 1'b1;
                    m_pclog = pc;
                    m_src   = 4'd0;
                    if (!cr_viol) begin
                        for (int i = NUM_UCC - 1; i >= 0; i--)
                            if (ucc_viol[i]) m_src = 4'(i + 1);
                    end
                end else begin
                    m_ovf = 1'b1;
                end
                if (m_count < 63) m_count++;
            end else if (data_en && data_wr && data_addr == CA && data_din == KEY && !m_hold() && !viol) begin
                m_valid = 1'b0;
                m_ovf   = 1'b0;
                m_count = 0;
                m_src   = 4'd0;
                m_pclog = 16'd0;
            end
            if (viol)              m_since = 1;
            else if (m_since < FAR) m_since++;
            m_dout = nd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        data_en = 1'b0; data_wr = 1'b0; data_addr = 16'd0; data_din = 16'd0;
    endtask

    task automatic bus_rd(input logic [15:0] a);
        data_en = 1'b1; data_wr = 1'b0; data_addr = a; data_din = 16'd0;
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
        data_en = 1'b1; data_wr = 1'b1; data_addr = a; data_din = d;
    endtask

    int high;

    initial begin
        // Power-on reset with a UCC violation held throughout.
        reset = 1'b1; cr_viol = 1'b0; ucc_viol = 4'b0010; pc = 16'h0000;
        bus_idle();
        @(posedge clk);
        #1;
        model_reset();
        repeat (3) tick();

        // Release: reset asserts in the same cycle and records UCC 1.
        reset = 1'b0;
        tick();
        ucc_viol = '0;
        bus_rd(CA);
        tick();
        bus_idle();
        check("por_cause", cause_dout, LOG ? 16'h8102 : 16'h8002);
        repeat (H + 2) tick();

        // Clear in IDLE.
        bus_wr(CA, KEY);
        tick();
        bus_rd(CA);
        tick();
        bus_idle();
        check("clear_idle", cause_dout, 16'h0000);

        // Single-cycle CR violation: RST_HOLD+1 cycles of reset.
        cr_viol = 1'b1;
        tick();
        cr_viol = 1'b0;
        high = int'(obs_mcu);
        repeat (H + 1) begin
            tick();
            high += int'(obs_mcu);
        end
        check("hold_len", 16'(high), 16'(H + 1));
        bus_rd(CA);
        tick();
        bus_idle();
        check("cr_src", cause_dout, LOG ? 16'h8100 : 16'h8000);

        // Simultaneous CR and UCC 0, then a second episode on UCC 2.
        bus_wr(CA, KEY);
        tick();
        bus_idle();
        cr_viol = 1'b1; ucc_viol = 4'b0001;
        tick();
        cr_viol = 1'b0; ucc_viol = '0;
        repeat (H + 1) tick();
        ucc_viol = 4'b0100;
        tick();
        ucc_viol = '0;
        repeat (H + 1) tick();
        bus_rd(CA);
        tick();
        bus_idle();
        check("ovf_src", cause_dout, LOG ? 16'hC200 : 16'hC000);

        // Violation in the final HOLD cycle restarts the hold with no gap.
        ucc_viol = 4'b1000;
        tick();
        ucc_viol = '0;
        repeat (H - 1) tick();
        ucc_viol = 4'b1000;
        tick();
        ucc_viol = '0;
        high = 0;
        repeat (H) begin
            tick();
            high += int'(obs_mcu);
        end
        check("restart_len", 16'(high), 16'(H));
        tick();

        // Clears that must be ignored: during HOLD, with a violation, wrong key.
        cr_viol = 1'b1;
        tick();
        cr_viol = 1'b0;
        bus_wr(CA, KEY);
        tick();
        bus_idle();
        repeat (H + 1) tick();
        ucc_viol = 4'b0001;
        bus_wr(CA, KEY);
        tick();
        ucc_viol = '0;
        bus_idle();
        repeat (H + 1) tick();
        bus_wr(CA, 16'h1234);
        tick();
        bus_rd(CA);
        tick();
        bus_idle();
        check("retained", 16'(cause_dout[15]), 16'd1);

        // PC log capture and survival across the hold.
        bus_wr(CA, KEY);
        tick();
        bus_idle();
        pc = 16'hE0A4; cr_viol = 1'b1;
        tick();
        cr_viol = 1'b0; pc = 16'h0000;
        bus_rd(CA + 16'd2);
        tick();
        bus_idle();
        check("pclog", cause_dout, LOG ? 16'hE0A4 : 16'h0000);
        repeat (H + 1) tick();
        bus_rd(CA + 16'd2);
        tick();
        bus_idle();
        check("pclog_after", cause_dout, LOG ? 16'hE0A4 : 16'h0000);

        // COUNT saturation across many episodes.
        bus_wr(CA, KEY);
        tick();
        bus_idle();
        repeat (70) begin
            cr_viol = 1'b1;
            tick();
            cr_viol = 1'b0;
            repeat (H + 1) tick();
        end
        bus_rd(CA);
        tick();
        bus_idle();
        check("count_sat", cause_dout, LOG ? 16'hFF00 : 16'hC000);

        // Randomized traffic against the model.
        repeat (3000) begin
            int r;
            reset    = ($urandom_range(0, 299) == 0);
            r        = $urandom_range(0, 15);
            cr_viol  = (r == 0);
            ucc_viol = (r == 1 || r == 2) ? NUM_UCC'($urandom) : '0;
            pc       = 16'($urandom);
            data_en  = $urandom_range(0, 1) == 1;
            data_wr  = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 3))
                0:       data_addr = CA;
                1:       data_addr = CA + 16'd2;
                2:       data_addr = CA + 16'd1;
                default: data_addr = 16'($urandom);
            endcase
            data_din = ($urandom_range(0, 1) == 1) ? KEY : 16'($urandom);
            tick();
        end
        reset = 1'b0; cr_viol = 1'b0; ucc_viol = '0;
        bus_idle();
        repeat (H + 2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
